// File: rtl/uart_char_receiver.sv
// uart_char_receiver: 8N1 serial receiver with 16x oversampling.
// The stop-bit check drives the outputs. A valid frame pulses we with the
// character on cout. A low stop bit gives a single frame_err pulse, and the
// block then waits for the line to return high.
module uart_char_receiver #(
    parameter int unsigned CLK_FREQ = 100000000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] cout,
    output logic       we,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned DIV = CLK_FREQ / (BAUD * 16);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      os_q, os_d;
    logic [2:0]      bi_q, bi_d;
    logic [7:0]      sh_q, sh_d;
    logic [7:0]      cout_q, cout_d;
    logic            load_q, load_d;
    logic            we_q, we_d;
    logic            fe_q, fe_d;
    logic            rx_meta_q, rx_s_q;
    logic            tick;

    assign tick      = (cnt_q == CW'(DIV - 1));
    assign cout      = cout_q;
    assign we        = we_q;
    assign frame_err = fe_q;
    assign busy      = (state_q != IDLE);

    // Two-flop synchronizer for the asynchronous line; idle level is high.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State, counters, data and output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            os_q    <= '0;
            bi_q    <= '0;
            sh_q    <= '0;
            cout_q  <= '0;
            load_q  <= 1'b0;
            we_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            os_q    <= os_d;
            bi_q    <= bi_d;
            sh_q    <= sh_d;
            cout_q  <= cout_d;
            load_q  <= load_d;
            we_q    <= we_d;
            fe_q    <= fe_d;
        end
    end

    // Next-state logic: tick generation, frame sequencing and the output strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = tick ? '0 : cnt_q + 1'b1;
        os_d    = os_q;
        bi_d    = bi_q;
        sh_d    = sh_q;
        load_d  = 1'b0;
        fe_d    = 1'b0;
        // The stop-bit check and the strobe are one register stage apart, so
        // we rises two cycles after the sampling tick. cout is loaded with it.
        we_d    = load_q;
        cout_d  = load_q ? sh_q : cout_q;

        unique case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    os_d    = '0;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (os_q == 4'd7) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            os_d    = '0;
                            bi_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_q == 4'd15) begin
                        sh_d[bi_q] = rx_s_q;
                        os_d       = '0;
                        if (bi_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bi_d = bi_q + 3'd1;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (os_q == 4'd15) begin
                        os_d = '0;
                        if (rx_s_q) begin
                            load_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            fe_d    = 1'b1;
                            state_d = WAIT_HIGH;
                        end
                    end else begin
                        os_d = os_q + 4'd1;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_char_receiver.sv
// Testbench for uart_char_receiver at DIV=10 (160 clk per bit).
// A monitor logs every output strobe. Each test task compares these logs
// with the frames its model expects.
module tb_uart_char_receiver;

    localparam int unsigned CLK_FREQ = 1600000;
    localparam int unsigned BAUD     = 10000;
    localparam int unsigned BIT      = 160;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] cout;
    logic       we;
    logic       frame_err;
    logic       busy;

    int unsigned asserts;
    int unsigned failures;

    // monitor logs
    logic [7:0]  got_q[$];
    int unsigned we_time_q[$];
    int unsigned we_cnt, fe_cnt, both_cnt, we_long, fe_long;
    int unsigned cyc;
    logic        we_prev, fe_prev;

    // model state
    logic [7:0]  exp_q[$];
    int unsigned exp_fe;
    logic [7:0]  last_good;

    uart_char_receiver #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx       (rx),
        .cout     (cout),
        .we       (we),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge.
    initial begin
        cyc = 0; we_cnt = 0; fe_cnt = 0; both_cnt = 0; we_long = 0; fe_long = 0;
        we_prev = 1'b0; fe_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (we === 1'b1) begin
                we_cnt++;
                got_q.push_back(cout);
                we_time_q.push_back(cyc);
                if (we_prev) we_long++;
            end
            if (frame_err === 1'b1) begin
                fe_cnt++;
                if (fe_prev) fe_long++;
            end
            if (we === 1'b1 && frame_err === 1'b1) both_cnt++;
            we_prev = (we === 1'b1);
            fe_prev = (frame_err === 1'b1);
        end
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        got_q.delete();
        we_time_q.delete();
        exp_q.delete();
        we_cnt = 0;
        fe_cnt = 0;
        exp_fe = 0;
    endtask

    // Drive one 8N1 frame and record the expected result.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clks(BIT);
        end
        rx = stop;
        wait_clks(BIT);
        if (stop) begin
            exp_q.push_back(data);
            last_good = data;
        end else begin
            exp_fe++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        last_good = 8'h00;
        wait_clks(5);
        asserts++; if (cout !== 8'h00) begin failures++; $display("FAIL reset_cout: got %h expected 00", cout); end
        asserts++; if (we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b expected 0", we); end
        asserts++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset_n = 1'b1;
        wait_clks(50);
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_single();
        logic [7:0] g;
        clear_logs();
        send_frame(8'h41, 1'b1);
        wait_clks(200);
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        asserts++; if (we_cnt != 1) begin failures++; $display("FAIL single_we_count: got %0d expected 1", we_cnt); end
        asserts++; if (g !== exp_q[0]) begin failures++; $display("FAIL single_data: got %h expected %h", g, exp_q[0]); end
        asserts++; if (fe_cnt != 0) begin failures++; $display("FAIL single_ferr: got %0d expected 0", fe_cnt); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b expected 0", busy); end
        asserts++; if (cout !== last_good) begin failures++; $display("FAIL single_cout_hold: got %h expected %h", cout, last_good); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  g0, g1;
        int unsigned gap;
        clear_logs();
        send_frame(8'h48, 1'b1);
        send_frame(8'h69, 1'b1);
        wait_clks(200);
        g0  = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        g1  = (got_q.size() > 1) ? got_q[1] : 8'hxx;
        gap = (we_time_q.size() > 1) ? we_time_q[1] - we_time_q[0] : 0;
        asserts++; if (we_cnt != 2) begin failures++; $display("FAIL b2b_we_count: got %0d expected 2", we_cnt); end
        asserts++; if (g0 !== exp_q[0]) begin failures++; $display("FAIL b2b_first: got %h expected %h", g0, exp_q[0]); end
        asserts++; if (g1 !== exp_q[1]) begin failures++; $display("FAIL b2b_second: got %h expected %h", g1, exp_q[1]); end
        asserts++; if (gap < 1595 || gap > 1605) begin failures++; $display("FAIL b2b_spacing: got %0d expected about 1600", gap); end
        asserts++; if (fe_cnt != 0) begin failures++; $display("FAIL b2b_ferr: got %0d expected 0", fe_cnt); end
    endtask

    task automatic test_glitch();
        int unsigned busy_cycles;
        clear_logs();
        busy_cycles = 0;
        rx = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
        rx = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
        asserts++; if (busy_cycles == 0 || busy_cycles > 90) begin failures++; $display("FAIL glitch_busy_len: got %0d expected 1..90", busy_cycles); end
        asserts++; if (we_cnt != 0) begin failures++; $display("FAIL glitch_we: got %0d expected 0", we_cnt); end
        asserts++; if (fe_cnt != 0) begin failures++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cnt); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_idle: busy=%b expected 0", busy); end
    endtask

    task automatic test_frame_error();
        logic [7:0] held, g;
        clear_logs();
        held = last_good;
        send_frame(8'h55, 1'b0);
        wait_clks(3000);
        asserts++; if (fe_cnt != exp_fe) begin failures++; $display("FAIL ferr_count: got %0d expected %0d", fe_cnt, exp_fe); end
        asserts++; if (we_cnt != 0) begin failures++; $display("FAIL ferr_no_we: got %0d expected 0", we_cnt); end
        asserts++; if (cout !== held) begin failures++; $display("FAIL ferr_cout_hold: got %h expected %h", cout, held); end
        asserts++; if (busy !== 1'b1) begin failures++; $display("FAIL ferr_wait_busy: got %b expected 1", busy); end
        rx = 1'b1;
        wait_clks(50);
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_recover_idle: busy=%b expected 0", busy); end
        send_frame(8'h7A, 1'b1);
        wait_clks(200);
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        asserts++; if (we_cnt != 1) begin failures++; $display("FAIL ferr_next_count: got %0d expected 1", we_cnt); end
        asserts++; if (g !== 8'h7A) begin failures++; $display("FAIL ferr_next_data: got %h expected 7a", g); end
        asserts++; if (fe_cnt != 1) begin failures++; $display("FAIL ferr_single_pulse: got %0d expected 1", fe_cnt); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] d, g;
        clear_logs();
        d = 8'hC3;
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_clks(BIT);
        end
        rx = d[4];
        wait_clks(80);
        reset_n = 1'b0;
        rx = 1'b1;
        last_good = 8'h00;
        wait_clks(5);
        reset_n = 1'b1;
        wait_clks(2000);
        asserts++; if (we_cnt != 0) begin failures++; $display("FAIL abort_no_we: got %0d expected 0", we_cnt); end
        asserts++; if (fe_cnt != 0) begin failures++; $display("FAIL abort_no_ferr: got %0d expected 0", fe_cnt); end
        asserts++; if (cout !== last_good) begin failures++; $display("FAIL abort_cout: got %h expected %h", cout, last_good); end
        send_frame(8'h31, 1'b1);
        wait_clks(200);
        g = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        asserts++; if (we_cnt != 1) begin failures++; $display("FAIL abort_next_count: got %0d expected 1", we_cnt); end
        asserts++; if (g !== 8'h31) begin failures++; $display("FAIL abort_next_data: got %h expected 31", g); end
    endtask

    task automatic test_boundary();
        logic [7:0] g0, g1;
        clear_logs();
        send_frame(8'h00, 1'b1);
        wait_clks(100);
        send_frame(8'hFF, 1'b1);
        wait_clks(200);
        g0 = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        g1 = (got_q.size() > 1) ? got_q[1] : 8'hxx;
        asserts++; if (we_cnt != 2) begin failures++; $display("FAIL bound_count: got %0d expected 2", we_cnt); end
        asserts++; if (g0 !== 8'h00) begin failures++; $display("FAIL bound_zero: got %h expected 00", g0); end
        asserts++; if (g1 !== 8'hFF) begin failures++; $display("FAIL bound_ones: got %h expected ff", g1); end
        asserts++; if (cout !== 8'hFF) begin failures++; $display("FAIL bound_hold: got %h expected ff", cout); end
    endtask

    task automatic test_random();
        logic [7:0] g;
        clear_logs();
        for (int n = 0; n < 8; n++) begin
            send_frame(8'($urandom), 1'b1);
            wait_clks($urandom_range(0, 200));
        end
        wait_clks(200);
        asserts++; if (we_cnt != exp_q.size()) begin failures++; $display("FAIL rand_count: got %0d expected %0d", we_cnt, exp_q.size()); end
        for (int n = 0; n < exp_q.size(); n++) begin
            g = (got_q.size() > n) ? got_q[n] : 8'hxx;
            asserts++; if (g !== exp_q[n]) begin failures++; $display("FAIL rand_data[%0d]: got %h expected %h", n, g, exp_q[n]); end
        end
        asserts++; if (fe_cnt != 0) begin failures++; $display("FAIL rand_ferr: got %0d expected 0", fe_cnt); end
    endtask

    task automatic test_pulse_integrity();
        asserts++; if (both_cnt != 0) begin failures++; $display("FAIL strobe_overlap: got %0d cycles expected 0", both_cnt); end
        asserts++; if (we_long != 0) begin failures++; $display("FAIL we_width: got %0d extra cycles expected 0", we_long); end
        asserts++; if (fe_long != 0) begin failures++; $display("FAIL ferr_width: got %0d extra cycles expected 0", fe_long); end
    endtask

    initial begin
        asserts  = 0;
        failures = 0;
        reset_n  = 1'b0;
        rx       = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_reset_abort();
        test_boundary();
        test_random();
        test_pulse_integrity();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/uart_char_receiver.md
UART_CHAR_RECEIVER -- requirements
Module: uart_char_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the serial bit rate.
REQ-003 SHALL define DIV = CLK_FREQ/(BAUD*16), truncated; the default DIV is 651.
REQ-004 clk  input  1  single system clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous, active-low.
REQ-006 rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-007 cout  output  8  received character; feeds the character feeder's cin.
REQ-008 we  output  1  one-cycle write strobe for cout; feeds the character feeder's we.
REQ-009 frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL pass rx through a 2-flop synchronizer preset to 1; rx_s is the second flop; all decisions use rx_s only.
REQ-012 SHALL generate the tick from a counter 0..DIV-1; tick is high for one cycle when the counter is at DIV-1, then the counter wraps to 0.
REQ-013 The tick counter SHALL free-run; the state machine SHALL clear it to 0 on the IDLE->START transition.
REQ-014 SHALL keep a 4-bit oversample counter os and a 3-bit bit index bi.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE: on rx_s==0, go to START and set os=0.
REQ-017 START: on each tick, increment os; at the tick where os==7, sample rx_s.
  - rx_s==0: go to DATA with os=0 and bi=0.
  - rx_s==1: glitch; return to IDLE with no output.
REQ-018 DATA: on each tick, increment os; at the tick where os==15, shift rx_s into bit bi of the shift register and set os=0.
  - bi==7: go to STOP.
  - otherwise: increment bi.
REQ-019 STOP: at the tick where os==15, sample rx_s.
  - rx_s==1: load cout with the shift register, pulse we on the next cycle, go to IDLE.
  - rx_s==0: pulse frame_err, leave cout and we unchanged, go to WAIT_HIGH.
REQ-020 WAIT_HIGH: stay until rx_s==1, then go to IDLE; a BREAK (line held low) SHALL produce exactly one frame_err.
REQ-021 we and frame_err SHALL each be high for exactly one clk cycle per event and never high in the same cycle.
REQ-022 cout SHALL hold its last value until the next valid frame; it SHALL be valid in the cycle we is high and after it.
REQ-023 Latency: we SHALL rise 2 clk cycles after the stop-bit sampling tick.
REQ-024 The receiver SHALL accept a new start bit in the cycle after it returns to IDLE, so back-to-back frames with one stop bit are received without loss.
REQ-025 Line changes between sampling ticks SHALL be ignored; there SHALL be no re-synchronisation inside a frame.

Reset
REQ-026 While reset_n==0 at a clk edge, the block SHALL force:
  - state=IDLE
  - tick counter, os and bi = 0
  - shift register and cout = 8'h00
  - we=0, frame_err=0, busy=0
  - synchronizer flops = 1
REQ-027 Reset asserted mid-frame SHALL abandon the frame without any we or frame_err.
REQ-028 After reset release the block SHALL wait in IDLE for a low rx_s.

Verification (CLK_FREQ=1600000, BAUD=10000 -> DIV=10, 160 clk per bit)
REQ-029 Send 8'h41 with 8N1 timing -> exactly one we pulse with cout=8'h41; frame_err stays 0; busy returns to 0.
REQ-030 Send 8'h48 then 8'h69 back-to-back (no idle gap) -> two we pulses, cout=8'h48 then 8'h69, about 1600 clk apart.
REQ-031 Send an rx low pulse of 40 clk, then idle -> no we, no frame_err; busy is high for no more than 90 clk, then state=IDLE.
REQ-032 Send 8'h55 with the stop bit driven low, then hold rx low for 3000 clk -> one frame_err pulse, no we, cout unchanged; after rx goes high, a following 8'h7A is received correctly.
REQ-033 Assert reset_n=0 at data bit 4 of 8'hC3, release, then send 8'h31 -> no output for the aborted frame; one we with cout=8'h31.
REQ-034 Send 8'h00 and 8'hFF -> cout=8'h00 and 8'hFF respectively, each with a single we pulse; this checks the boundary data patterns.
